// File: rtl/ept_operand_sequencer_if.sv
// Byte-stream and operator-block signal bundle for ept_operand_sequencer.
// slave is the sequencer's view; master is the host/operator-block view.
interface ept_operand_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [7:0] opcode;
    logic [7:0] result_in;
    logic       busy;
    logic       frame_err;
    logic [7:0] frame_count;

    modport slave (
        input  rx_data, rx_valid, tx_ready, result_in,
        output rx_ready, tx_data, tx_valid, operand_a, operand_b, opcode,
               busy, frame_err, frame_count
    );

    modport master (
        output rx_data, rx_valid, tx_ready, result_in,
        input  rx_ready, tx_data, tx_valid, operand_a, operand_b, opcode,
               busy, frame_err, frame_count
    );
endinterface

// File: rtl/ept_operand_sequencer.sv
// Request/response framer in front of the 8-bit operator block.
// Parses header/opcode/A/B request frames, drives registered operands, waits a fixed
// settle time, captures the result and returns header/opcode/result/status.
// Optional macro EPT_OPSEQ_CHECKSUM_EN adds a checksum byte to both frame directions.
module ept_operand_sequencer #(
    parameter int unsigned NUM_OPS        = 16,
    parameter int unsigned DIV_OPCODE     = 3,
    parameter int unsigned RESULT_LATENCY = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  REQ_HDR        = 8'hA5,
    parameter logic [7:0]  RSP_HDR        = 8'h5A
) (
    input  logic                      clk_66,
    input  logic                      rst,
    ept_operand_sequencer_if.slave    bus
);

    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [ToW-1:0] ToMax  = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]     LatMax = 4'(RESULT_LATENCY - 1);
    localparam logic [8:0]     NumOps = 9'(NUM_OPS);
    localparam logic [7:0]     DivOp  = 8'(DIV_OPCODE);

    typedef enum logic [3:0] {
        StIdle, StGetOp, StGetA, StGetB, StGetCk, StExec,
        StSendHdr, StSendOp, StSendRes, StSendStat, StSendCk
    } state_e;

    state_e         state_q, state_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]     lat_cnt_q, lat_cnt_d;
    logic [7:0]     op_sh_q, a_sh_q;
    logic [7:0]     operand_a_q, operand_b_q, opcode_q;
    logic [7:0]     result_q, status_q;
    logic [7:0]     frame_count_q;
    logic           frame_err_q;
`ifdef EPT_OPSEQ_CHECKSUM_EN
    logic [7:0]     ck_sh_q;
`endif

    logic       rx_ready_c, rx_acc;
    logic       tx_valid_c;
    logic [7:0] tx_data_c;
    logic       load, capture, abort, frame_done;
    logic [7:0] status_c, result_c;

    // Status and forced result for the frame currently in EXEC; first match wins.
    always_comb begin
        status_c = 8'h00;
        result_c = bus.result_in;
`ifdef EPT_OPSEQ_CHECKSUM_EN
        if (ck_sh_q != (opcode_q ^ operand_a_q ^ operand_b_q)) begin
            status_c = 8'h03;
            result_c = 8'h00;
        end else
`endif
        if ({1'b0, opcode_q} >= NumOps) begin
            status_c = 8'h01;
            result_c = 8'h00;
        end else if (opcode_q == DivOp && operand_b_q == 8'h00) begin
            status_c = 8'h02;
            result_c = 8'h00;
        end
    end

    // Next-state, counters and handshake outputs.
    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        load       = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        frame_done = 1'b0;
        tx_valid_c = 1'b0;
        tx_data_c  = 8'h00;
        rx_ready_c = (state_q == StIdle) || (state_q == StGetOp) || (state_q == StGetA) ||
                     (state_q == StGetB) || (state_q == StGetCk);
        rx_acc     = bus.rx_valid && rx_ready_c;

        unique case (state_q)
            StIdle: begin
                to_cnt_d = '0;
                if (rx_acc && bus.rx_data == REQ_HDR) state_d = StGetOp;
            end
            StGetOp, StGetA, StGetB, StGetCk: begin
                if (rx_acc) begin
                    to_cnt_d = '0;
                    unique case (state_q)
                        StGetOp: state_d = StGetA;
                        StGetA:  state_d = StGetB;
                        StGetB: begin
                            load = 1'b1;
`ifdef EPT_OPSEQ_CHECKSUM_EN
                            state_d = StGetCk;
`else
                            state_d = StExec;
`endif
                        end
                        default: state_d = StExec;
                    endcase
                end else if (to_cnt_q == ToMax) begin
                    abort    = 1'b1;
                    to_cnt_d = '0;
                    state_d  = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StExec: begin
                if (lat_cnt_q == LatMax) begin
                    capture   = 1'b1;
                    lat_cnt_d = '0;
                    state_d   = StSendHdr;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            StSendHdr: begin
                tx_valid_c = 1'b1;
                tx_data_c  = RSP_HDR;
                if (bus.tx_ready) state_d = StSendOp;
            end
            StSendOp: begin
                tx_valid_c = 1'b1;
                tx_data_c  = opcode_q;
                if (bus.tx_ready) state_d = StSendRes;
            end
            StSendRes: begin
                tx_valid_c = 1'b1;
                tx_data_c  = result_q;
                if (bus.tx_ready) state_d = StSendStat;
            end
            StSendStat: begin
                tx_valid_c = 1'b1;
                tx_data_c  = status_q;
                if (bus.tx_ready) begin
`ifdef EPT_OPSEQ_CHECKSUM_EN
                    state_d = StSendCk;
`else
                    frame_done = 1'b1;
                    state_d    = StIdle;
`endif
                end
            end
            StSendCk: begin
                tx_valid_c = 1'b1;
                tx_data_c  = RSP_HDR ^ opcode_q ^ result_q ^ status_q;
                if (bus.tx_ready) begin
                    frame_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, shadow, operand and result registers with synchronous reset.
    always_ff @(posedge clk_66) begin
        if (rst) begin
            state_q       <= StIdle;
            to_cnt_q      <= '0;
            lat_cnt_q     <= '0;
            op_sh_q       <= 8'h00;
            a_sh_q        <= 8'h00;
            operand_a_q   <= 8'h00;
            operand_b_q   <= 8'h00;
            opcode_q      <= 8'h00;
            result_q      <= 8'h00;
            status_q      <= 8'h00;
            frame_count_q <= 8'h00;
            frame_err_q   <= 1'b0;
`ifdef EPT_OPSEQ_CHECKSUM_EN
            ck_sh_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            frame_err_q <= abort;
            if (rx_acc && state_q == StGetOp) op_sh_q <= bus.rx_data;
            if (rx_acc && state_q == StGetA)  a_sh_q  <= bus.rx_data;
`ifdef EPT_OPSEQ_CHECKSUM_EN
            if (rx_acc && state_q == StGetCk) ck_sh_q <= bus.rx_data;
`endif
            // B goes straight to the operand register on the byte it arrives with.
            if (load) begin
                opcode_q    <= op_sh_q;
                operand_a_q <= a_sh_q;
                operand_b_q <= bus.rx_data;
            end
            if (capture) begin
                result_q <= result_c;
                status_q <= status_c;
            end
            if (frame_done) frame_count_q <= frame_count_q + 8'h01;
        end
    end

    // Outputs held at zero while reset is asserted.
    assign bus.rx_ready    = rx_ready_c && !rst;
    assign bus.tx_valid    = tx_valid_c;
    assign bus.tx_data     = tx_data_c;
    assign bus.operand_a   = operand_a_q;
    assign bus.operand_b   = operand_b_q;
    assign bus.opcode      = opcode_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_ept_operand_sequencer.sv
// Directed bench for ept_operand_sequencer; operator block modelled as A*B for opcode 2,
// A+B otherwise.
module tb_ept_operand_sequencer;

    localparam int T = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ept_operand_sequencer_if bus ();

    ept_operand_sequencer dut (
        .clk_66 (clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign bus.result_in = (bus.opcode == 8'h02) ? 8'(bus.operand_a * bus.operand_b)
                                                 : 8'(bus.operand_a + bus.operand_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte; returns at the negedge after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rx_ready_wait", bus.rx_ready, 1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!bus.tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({tag, "_valid_wait"}, bus.tx_valid, 1);
        check(tag, bus.tx_data, exp);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
    endtask

    task automatic send_req(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        send_byte(8'hA5);
        send_byte(op);
        send_byte(a);
        send_byte(b);
`ifdef EPT_OPSEQ_CHECKSUM_EN
        send_byte(op ^ a ^ b);
`endif
    endtask

    task automatic recv_rsp(input string tag, input logic [7:0] op, input logic [7:0] res,
                            input logic [7:0] st);
        recv_byte({tag, "_hdr"}, 8'h5A);
        recv_byte({tag, "_op"}, op);
        recv_byte({tag, "_res"}, res);
        recv_byte({tag, "_stat"}, st);
`ifdef EPT_OPSEQ_CHECKSUM_EN
        recv_byte({tag, "_ck"}, 8'h5A ^ op ^ res ^ st);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int first;
        int txv;
        logic busy_before;
        logic held;
        int n;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_rx_ready", bus.rx_ready, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_operand_a", bus.operand_a, 0);
        check("rst_operand_b", bus.operand_b, 0);
        check("rst_opcode", bus.opcode, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_frame_count", bus.frame_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_rx_ready", bus.rx_ready, 1);

        // Addition.
        send_req(8'h00, 8'h12, 8'h34);
        check("f1_busy", bus.busy, 1);
        check("f1_operand_a", bus.operand_a, 8'h12);
        check("f1_operand_b", bus.operand_b, 8'h34);
        recv_rsp("f1", 8'h00, 8'h46, 8'h00);
        check("f1_done_busy", bus.busy, 0);
        check("f1_done_tx_valid", bus.tx_valid, 0);
        check("f1_frame_count", bus.frame_count, 1);

        // Division by zero.
        send_req(8'h03, 8'h40, 8'h00);
        check("f2_operand_b", bus.operand_b, 8'h00);
        check("f2_opcode", bus.opcode, 8'h03);
        recv_rsp("f2", 8'h03, 8'h00, 8'h02);
        check("f2_frame_count", bus.frame_count, 2);

        // Opcode out of range.
        send_req(8'h14, 8'h01, 8'h01);
        recv_rsp("f3", 8'h14, 8'h00, 8'h01);
        check("f3_frame_count", bus.frame_count, 3);

        // Junk byte dropped, then stalled response.
        send_byte(8'h77);
        check("junk_busy", bus.busy, 0);
        send_req(8'h02, 8'h09, 8'h03);
        n = 0;
        while (!bus.tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(bus.tx_valid && bus.tx_data == 8'h5A)) held = 1'b0;
            @(negedge clk);
        end
        check("stall_hold", held, 1);
        check("stall_tx_data", bus.tx_data, 8'h5A);
        recv_rsp("f4", 8'h02, 8'h1B, 8'h00);
        check("f4_frame_count", bus.frame_count, 4);

        // Timeout abort after two bytes.
        send_byte(8'hA5);
        send_byte(8'h01);
        errs = 0;
        first = 0;
        txv = 0;
        busy_before = 1'b0;
        for (int i = 1; i <= T + 20; i++) begin
            @(negedge clk);
            if (bus.frame_err) begin
                errs++;
                first = i;
            end
            if (bus.tx_valid) txv++;
            if (i == T - 1) busy_before = bus.busy;
        end
        check("to_pulse_count", errs, 1);
        check("to_pulse_time", first, T);
        check("to_busy_before", busy_before, 1);
        check("to_no_tx", txv, 0);
        check("to_busy_after", bus.busy, 0);
        check("to_operand_a", bus.operand_a, 8'h09);
        check("to_opcode", bus.opcode, 8'h02);
        check("to_frame_count", bus.frame_count, 4);

        // Normal frame after abort.
        send_req(8'h00, 8'h05, 8'h06);
        recv_rsp("f5", 8'h00, 8'h0B, 8'h00);
        check("f5_frame_count", bus.frame_count, 5);

`ifdef EPT_OPSEQ_CHECKSUM_EN
        send_req(8'h00, 8'h01, 8'h02);
        recv_rsp("ck_good", 8'h00, 8'h03, 8'h00);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'hFF);
        recv_rsp("ck_bad", 8'h00, 8'h00, 8'h03);
        check("ck_frame_count", bus.frame_count, 7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
